// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin front end that time-shares one pipelined
// Q2.13 multiplier between N_REQ requesters and routes each product back to
// its owner. Optional feature macro: MUL_ARB_TIMEOUT_EN (adds O_ERR and a
// WAIT watchdog that returns a zero product if the multiplier never answers).
module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2
`ifdef MUL_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic                  I_CLK,
  input  logic                  I_RST_N,
  input  logic [N_REQ-1:0]      I_REQ,
  input  logic [16*N_REQ-1:0]   I_REQ_M1,
  input  logic [16*N_REQ-1:0]   I_REQ_M2,
  output logic [N_REQ-1:0]      O_GNT,
  output logic [N_REQ-1:0]      O_RSP_VLD,
  output logic [ID_W-1:0]       O_RSP_ID,
  output logic [15:0]           O_RSP_PRODUCT,
  output logic                  O_BUSY,
  output logic                  O_MUL_VLD,
  output logic [15:0]           O_MUL_M1,
  output logic [15:0]           O_MUL_M2,
`ifdef MUL_ARB_TIMEOUT_EN
  output logic                  O_ERR,
`endif
  input  logic                  I_MUL_VLD,
  input  logic                  I_MUL_BUSY,
  input  logic [15:0]           I_MUL_PRODUCT
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]  rsp_vld_q, rsp_vld_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [15:0]       rsp_prod_q, rsp_prod_d;
`ifdef MUL_ARB_TIMEOUT_EN
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  logic              found;
  logic [ID_W-1:0]   win;
  logic [ID_W:0]     cand;
  logic [ID_W:0]     nxt;
  logic              issue;

  // Priority search starting at the RR pointer, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!found && I_REQ[cand[ID_W-1:0]]) begin
        found = 1'b1;
        win   = cand[ID_W-1:0];
      end
    end
  end

  // Issue only from IDLE and only when the multiplier is free; operands and
  // grant go out in the same cycle so the requester sees when it was sampled.
  always_comb begin
    issue     = (state_q == S_IDLE) && found && !I_MUL_BUSY;
    O_MUL_VLD = issue;
    O_MUL_M1  = '0;
    O_MUL_M2  = '0;
    O_GNT     = '0;
    if (issue) begin
      O_MUL_M1   = I_REQ_M1[16*win +: 16];
      O_MUL_M2   = I_REQ_M2[16*win +: 16];
      O_GNT[win] = 1'b1;
    end
  end

  // Next-state: pointer advance on issue, response capture in WAIT.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    rsp_vld_d  = '0;
    rsp_id_d   = rsp_id_q;
    rsp_prod_d = rsp_prod_q;
    nxt        = {1'b0, win} + (ID_W+1)'(1);
    if (nxt >= (ID_W+1)'(N_REQ)) nxt = '0;
`ifdef MUL_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          owner_d = win;
          ptr_d   = nxt[ID_W-1:0];
          state_d = S_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (I_MUL_VLD) begin
          // A real result always beats a coincident timeout.
          rsp_vld_d[owner_q] = 1'b1;
          rsp_id_d           = owner_q;
          rsp_prod_d         = I_MUL_PRODUCT;
          state_d            = S_IDLE;
        end
`ifdef MUL_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(TIMEOUT)) begin
            rsp_vld_d[owner_q] = 1'b1;
            rsp_id_d           = owner_q;
            rsp_prod_d         = '0;
            err_d              = 1'b1;
            state_d            = S_IDLE;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight result.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      rsp_vld_q  <= '0;
      rsp_id_q   <= '0;
      rsp_prod_q <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_prod_q <= rsp_prod_d;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign O_RSP_VLD     = rsp_vld_q;
  assign O_RSP_ID      = rsp_id_q;
  assign O_RSP_PRODUCT = rsp_prod_q;
  assign O_BUSY        = (state_q == S_WAIT);
`ifdef MUL_ARB_TIMEOUT_EN
  assign O_ERR         = err_q;
`endif

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one 16-bit pipelined multiplier (Q2.13 signed operands; 1 accept cycle plus 4 busy cycles) between N_REQ requesters.
- Round-robin arbitration; issues the winner's operands to the multiplier and captures the product.
- Returns the product to the winning requester, tagged by requester index.
- Sits between the attention-datapath units and the single shared multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester index width, equal to clog2(N_REQ)
- TIMEOUT, 15, maximum wait cycles for I_MUL_VLD; used only with the optional feature

Ports:
- I_CLK  in  1  clock
- I_RST_N  in  1  asynchronous active-low reset
- I_REQ  in  N_REQ  per-requester request, level, held until granted
- I_REQ_M1  in  16*N_REQ  packed multiplicands; requester k uses bits [16k+15:16k]
- I_REQ_M2  in  16*N_REQ  packed multipliers, same packing
- O_GNT  out  N_REQ  one-hot grant pulse; operands sampled this cycle
- O_RSP_VLD  out  N_REQ  one-hot result-valid pulse
- O_RSP_ID  out  ID_W  index of requester owning O_RSP_PRODUCT
- O_RSP_PRODUCT  out  16  product
- O_BUSY  out  1  operation outstanding (state != IDLE)
- O_MUL_VLD  out  1  to multiplier I_VLD
- O_MUL_M1  out  16  to multiplier I_M1
- O_MUL_M2  out  16  to multiplier I_M2
- I_MUL_VLD  in  1  from multiplier O_VLD
- I_MUL_BUSY  in  1  from multiplier O_MUL_BUSY
- I_MUL_PRODUCT  in  16  from multiplier O_PRODUCT
- O_ERR  out  1  sticky timeout flag; present only with the optional feature

Behaviour:
- Reset values: all registered outputs 0, state IDLE, RR pointer 0, owner ID 0.
- FSM has two states, IDLE and WAIT.
- IDLE arbitration:
  - Combinational priority search starting at RR pointer, wrapping modulo N_REQ.
  - Issue condition: |I_REQ & !I_MUL_BUSY.
  - On issue, same cycle: O_MUL_VLD=1, O_MUL_M1/M2 = winner's operand slices, O_GNT[winner]=1.
  - Registered on the issuing edge: owner ID <= winner, RR pointer <= (winner+1) mod N_REQ, state <= WAIT.
  - With no issue, O_MUL_VLD=0, O_GNT=0 and O_MUL_M1/M2=0.
- Requester rules:
  - A requester drops I_REQ or presents new operands on the cycle after its O_GNT.
  - A request held after grant is a new request.
- WAIT:
  - O_MUL_VLD=0.
  - On I_MUL_VLD: O_RSP_PRODUCT <= I_MUL_PRODUCT, O_RSP_ID <= owner, O_RSP_VLD <= onehot(owner) for exactly one cycle, state <= IDLE.
  - O_RSP_PRODUCT and O_RSP_ID hold their value until the next response.
- Timing with issue at cycle 0:
  - I_MUL_VLD is high in cycle 4.
  - O_RSP_VLD is high in cycle 5.
  - The next issue is possible in cycle 5, giving 5-cycle throughput.
- Fairness: a continuously requesting requester is granted within N_REQ issues.
- Spurious I_MUL_VLD in IDLE is ignored; no response is produced.
- I_MUL_BUSY high in IDLE (multiplier driven elsewhere) blocks issue and leaves the pointer unchanged.
- A request present at the same edge that a response is registered is eligible for issue in that cycle.
- Reset mid-operation: all state clears immediately; the in-flight result is discarded with no response. The multiplier shares I_RST_N.
- Arithmetic: pass-through only; no width conversion.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit counter clears on issue and increments each WAIT cycle.
  - If it reaches TIMEOUT without I_MUL_VLD: state <= IDLE, O_ERR <= 1 (sticky until reset), O_RSP_VLD <= onehot(owner), O_RSP_PRODUCT <= 0.
  - I_MUL_VLD arriving in the same cycle as the timeout wins: normal response, no error.
- Undefined: no counter, no O_ERR port; WAIT lasts until I_MUL_VLD.

Test Plan:
- Single request: I_REQ=0001, M1=0x2000, M2=0x2000 at cycle 0. Expected: O_GNT=0001 and O_MUL_VLD in cycle 0; O_RSP_VLD=0001, O_RSP_ID=0, O_RSP_PRODUCT=0x2000 in cycle 5.
- Signed operands: requester 2 with M1=0x1000, M2=0xE000. Expected: O_RSP_VLD=0100, O_RSP_ID=2, O_RSP_PRODUCT=0xF000.
- Round robin: I_REQ=1111 held. Expected: grants 0001,0010,0100,1000,0001 at cycles 0,5,10,15,20, each followed by the matching O_RSP_VLD 5 cycles later.
- Wrap/skip: pointer=3 with I_REQ=0101. Expected: requester 0 granted, then requester 2.
- Reset mid-operation: I_RST_N low in cycle 2 after an issue. Expected: outputs 0 immediately, no O_RSP_VLD, next grant goes to requester 0.
- With MUL_ARB_TIMEOUT_EN and a stubbed multiplier that never asserts I_MUL_VLD. Expected: O_ERR=1 and O_RSP_VLD pulse with product 0 at cycle 16 (TIMEOUT=15), then IDLE.
